// File: rtl/sse_corrector_pipe.sv
// Pipelined GF(2^8) single-symbol-error corrector: syndromes -> logs -> classify/fix, valid/ready.
// Latency 3 cycles (syndrome reg, log reg, output reg), one word per cycle.
// Backpressure: the whole pipe freezes while out_valid && !out_ready; bubbles are kept.
module sse_corrector_pipe #(
  parameter int K = 8,
  parameter logic [8*K-1:0] LOC_EXP = {8'd230, 8'd215, 8'd184, 8'd141, 8'd108, 8'd63, 8'd39, 8'd25},
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*(K+2)-1:0] codeword_in,
  input  logic               corr_en_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*K-1:0]     data_out,
  output logic [1:0]         decode_result_out,
  output logic [4:0]         err_sym_out,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   ce_cnt,
  output logic [CNT_W-1:0]   due_cnt
);

  localparam int CW_W = 8 * (K + 2);
  localparam int DW   = 8 * K;
  localparam logic [1:0] RES_NE  = 2'b00;
  localparam logic [1:0] RES_CE  = 2'b01;
  localparam logic [1:0] RES_DUE = 2'b10;
  localparam logic [4:0] NO_SYM  = 5'd31;
  localparam logic [4:0] P0_SYM  = 5'(K);
  localparam logic [4:0] P1_SYM  = 5'(K + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          en;
    logic [7:0]    s0;
    logic [7:0]    s1;
  } st1_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          en;
    logic [7:0]    ls0;
    logic [7:0]    l;
    logic          z0;
    logic          z1;
  } st2_t;

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h5F) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int j = 0; j < 8; j++) begin
      if (b[j]) p = p ^ x;
      x = gf_mul2(x);
    end
    return p;
  endfunction

  // alpha^n by square-and-multiply over the exponent bits
  function automatic logic [7:0] gf_pow(input logic [7:0] n);
    logic [7:0] p, c;
    p = 8'h01;
    c = 8'h02;
    for (int j = 0; j < 8; j++) begin
      if (n[j]) p = gf_mul(p, c);
      c = gf_mul(c, c);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_log(input logic [7:0] x);
    logic [7:0] p, r;
    p = 8'h01;
    r = 8'h00;
    for (int j = 0; j < 255; j++) begin
      if (p == x) r = 8'(j);
      p = gf_mul2(p);
    end
    return r;
  endfunction

  function automatic logic [7:0] mod255_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} + 9'd255 - {1'b0, b};
    if (t >= 9'd255) t = t - 9'd255;
    return t[7:0];
  endfunction

  function automatic logic [7:0] mod255_dbl(input logic [7:0] e);
    logic [8:0] t;
    t = {1'b0, e} + {1'b0, e};
    if (t >= 9'd255) t = t - 9'd255;
    return t[7:0];
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [7:0] p0_term [K];
  logic [7:0] p1_term [K];
  logic [7:0] syn0, syn1;

  for (genvar g = 0; g < K; g++) begin : g_syn
    localparam logic [7:0] C0 = gf_pow(LOC_EXP[8*g +: 8]);
    localparam logic [7:0] C1 = gf_pow(mod255_dbl(LOC_EXP[8*g +: 8]));
    assign p0_term[g] = gf_mul(codeword_in[CW_W-1-8*g -: 8], C0);
    assign p1_term[g] = gf_mul(codeword_in[CW_W-1-8*g -: 8], C1);
  end

  always_comb begin
    syn0 = codeword_in[15:8];
    syn1 = codeword_in[7:0];
    for (int i = 0; i < K; i++) begin
      syn0 = syn0 ^ p0_term[i];
      syn1 = syn1 ^ p1_term[i];
    end
  end

  logic s1_vld, s2_vld;
  st1_t s1_q;
  st2_t s2_q;
  logic [7:0] ls0, ls1;

  assign ls0 = gf_log(s1_q.s0);
  assign ls1 = gf_log(s1_q.s1);

  logic [4:0]    m_cnt, m_idx;
  logic [7:0]    m_exp, corr_val;
  logic          do_fix;
  logic [DW-1:0] fix_dat;
  logic [1:0]    fix_res;
  logic [4:0]    fix_sym;

  always_comb begin
    m_cnt = 5'd0;
    m_idx = 5'd0;
    m_exp = 8'd0;
    for (int i = 0; i < K; i++) begin
      if (s2_q.l == LOC_EXP[8*i +: 8]) begin
        m_cnt = m_cnt + 5'd1;
        m_idx = 5'(i);
        m_exp = LOC_EXP[8*i +: 8];
      end
    end
    corr_val = gf_pow(mod255_sub(s2_q.ls0, m_exp));
    fix_dat  = s2_q.dat;
    fix_res  = RES_NE;
    fix_sym  = NO_SYM;
    do_fix   = 1'b0;
    if (s2_q.z0 && s2_q.z1) begin
      fix_res = RES_NE;
    end else if (!s2_q.en) begin
      fix_res = RES_DUE;
    end else if (s2_q.z1) begin
      fix_res = RES_CE;
      fix_sym = P0_SYM;
    end else if (s2_q.z0) begin
      fix_res = RES_CE;
      fix_sym = P1_SYM;
    end else if (m_cnt == 5'd1) begin
      fix_res = RES_CE;
      fix_sym = m_idx;
      do_fix  = 1'b1;
    end else begin
      fix_res = RES_DUE;
    end
    for (int i = 0; i < K; i++) begin
      if (do_fix && m_idx == 5'(i)) fix_dat[DW-1-8*i -: 8] = s2_q.dat[DW-1-8*i -: 8] ^ corr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld            <= 1'b0;
      s1_q              <= '0;
      s2_vld            <= 1'b0;
      s2_q              <= '0;
      out_valid         <= 1'b0;
      data_out          <= '0;
      decode_result_out <= RES_NE;
      err_sym_out       <= NO_SYM;
    end else if (adv) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_q.dat <= codeword_in[CW_W-1:16];
        s1_q.en  <= corr_en_in;
        s1_q.s0  <= syn0;
        s1_q.s1  <= syn1;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_q.dat <= s1_q.dat;
        s2_q.en  <= s1_q.en;
        s2_q.ls0 <= ls0;
        s2_q.l   <= mod255_sub(ls1, ls0);
        s2_q.z0  <= (s1_q.s0 == 8'h00);
        s2_q.z1  <= (s1_q.s1 == 8'h00);
      end
      out_valid <= s2_vld;
      if (s2_vld) begin
        data_out          <= fix_dat;
        decode_result_out <= fix_res;
        err_sym_out       <= fix_sym;
      end
    end
  end

  // clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt  <= '0;
      due_cnt <= '0;
    end else if (cnt_clr) begin
      ce_cnt  <= '0;
      due_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (decode_result_out == RES_CE && ce_cnt != CNT_MAX) ce_cnt <= ce_cnt + CNT_W'(1);
      if (decode_result_out == RES_DUE && due_cnt != CNT_MAX) due_cnt <= due_cnt + CNT_W'(1);
    end
  end

endmodule
